// File: rtl/ccff_loader.sv
// ccff_loader
//   Streams a configuration bitstream into a serial DFF chain (ccff).
//   Words are taken over a valid/ready handshake and shifted out MSB first,
//   one bit per cycle, on ccff_head while ccff_en opens the chain clock gate.
//   Exactly cfg_len bits reach the chain per load. Leftover bits of the last
//   word are dropped. Ones seen on ccff_tail during the load are counted.
//
// Ports
//   prog_clk      clock; every state update happens on its rising edge
//   prog_reset_n  asynchronous active-low reset
//   start         one-cycle load request, honoured only while idle
//   cfg_len       chain bits to shift, captured when start is accepted
//   word_data     bitstream word, MSB shifted first
//   word_valid    word_data is valid
//   word_ready    loader takes word_data this cycle
//   ccff_head     serial data into the first chain DFF
//   ccff_en       chain shift enable (drives the external clock gate)
//   ccff_tail     serial output of the last chain DFF
//   busy          high whenever a load is in progress
//   done          one-cycle pulse when a load completes
//   tail_ones     saturating count of 1s sampled on ccff_tail in the last load
module ccff_loader #(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 20
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  tail_ones
);

  localparam int POS_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_SHIFT  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]        state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  bit_cnt;
  logic [LEN_W-1:0]  bit_cnt_nxt;
  logic [POS_W-1:0]  word_pos;
  logic [WORD_W-1:0] shift_reg;
  logic              last_bit;
  logic              word_last;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v,
                                               input logic inc);
    if (inc && (v != {LEN_W{1'b1}}))
      sat_inc = v + 1'b1;
    else
      sat_inc = v;
  endfunction

  // bit_cnt only ever counts up to len_q, so with len_q = 2^LEN_W-1 the
  // match fires at the maximum value and bit_cnt never wraps.
  assign bit_cnt_nxt = bit_cnt + 1'b1;
  assign last_bit    = (bit_cnt_nxt == len_q);
  assign word_last   = (word_pos == POS_W'(WORD_W - 1));

  assign word_ready = (state == S_FETCH);
  assign ccff_en    = (state == S_SHIFT);
  assign ccff_head  = (state == S_SHIFT) ? shift_reg[WORD_W-1] : 1'b0;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FINISH);

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state     <= S_IDLE;
      len_q     <= '0;
      bit_cnt   <= '0;
      word_pos  <= '0;
      shift_reg <= '0;
      tail_ones <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q     <= cfg_len;
            bit_cnt   <= '0;
            tail_ones <= '0;
            state     <= (cfg_len == '0) ? S_FINISH : S_FETCH;
          end
        end
        // word_ready is high here, so word_valid alone completes the handshake.
        S_FETCH: begin
          if (word_valid) begin
            shift_reg <= word_data;
            word_pos  <= '0;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
          bit_cnt   <= bit_cnt_nxt;
          word_pos  <= word_pos + 1'b1;
          tail_ones <= sat_inc(tail_ones, ccff_tail);
          // Reaching the length wins over running out of word bits.
          if (last_bit)
            state <= S_FINISH;
          else if (word_last)
            state <= S_FETCH;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
